// File: rtl/bcd_pair_converter_if.sv
// bcd_pair_converter_if
//   Request/result bundle between a score source and the dual BCD converter.
//   master : drives START, VALUE_1, VALUE_2; observes the results.
//   slave  : the converter; drives TO_OUTPUT, BUSY, DONE, OVERFLOW.
// Signals:
//   START      request a conversion (taken only while the converter is idle)
//   VALUE_1    binary value for the left digit group  (BIN_W bits)
//   VALUE_2    binary value for the right digit group (BIN_W bits)
//   TO_OUTPUT  packed BCD display word, {value 1, value 2}
//   BUSY       conversion in progress
//   DONE       one-cycle pulse when TO_OUTPUT has just been updated
//   OVERFLOW   an input of the last accepted conversion was saturated
interface bcd_pair_converter_if #(
  parameter int BIN_W = 14
);
  logic             START;
  logic [BIN_W-1:0] VALUE_1;
  logic [BIN_W-1:0] VALUE_2;
  logic [31:0]      TO_OUTPUT;
  logic             BUSY;
  logic             DONE;
  logic             OVERFLOW;

  modport master (
    output START, VALUE_1, VALUE_2,
    input  TO_OUTPUT, BUSY, DONE, OVERFLOW
  );

  modport slave (
    input  START, VALUE_1, VALUE_2,
    output TO_OUTPUT, BUSY, DONE, OVERFLOW
  );
endinterface

// File: rtl/bcd_pair_converter.sv
// bcd_pair_converter
//   Converts two unsigned binary values into two 4-digit BCD groups with the
//   shift-add-3 (double dabble) algorithm, one bit per clock, both values in
//   parallel. The result is packed into the 32-bit word feeding the 8-digit
//   seven-segment scanner: value 1 on the left four digits, value 2 on the
//   right four. Inputs above MAX_VAL are clamped to MAX_VAL and flagged.
// Ports:
//   CLK  system clock
//   RST  synchronous, active-high reset (wins over START, aborts a conversion)
//   bus  slave side of bcd_pair_converter_if (START/VALUE_n in, results out)
// Parameters:
//   BIN_W    width of each binary input (14 covers 0..9999)
//   MAX_VAL  saturation limit applied to each input
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits of each group
//                          are replaced by the blank code 4'hF (the ones digit
//                          is always shown).
module bcd_pair_converter #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input logic                CLK,
  input logic                RST,
  bcd_pair_converter_if.slave bus
);

  localparam int               CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             load_en, shift_en, last_shift;

  logic [1:0]       over_w;
  logic [1:0][15:0] acc_shift_w;

  logic [31:0]      to_output_reg;
  logic             done_reg;
  logic             overflow_reg;
  logic             ovf_cap_reg;

  // One double-dabble step: correct every nibble >= 5 by +3, then shift the
  // next binary bit in at the bottom.
  function automatic logic [15:0] dd_step(input logic [15:0] acc, input logic in_bit);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    return {adj[14:0], in_bit};
  endfunction

  // Final formatting of one 4-digit group before it reaches the display.
  function automatic logic [15:0] fmt_group(input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] r;
    r = d;
    // Nested tests keep blanking contiguous from the left; ones never blank.
    if (d[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (d[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (d[7:4] == 4'd0) begin
          r[7:4] = 4'hF;
        end
      end
    end
    return r;
`else
    return d;
`endif
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.START) state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    load_en    = 1'b0;
    shift_en   = 1'b0;
    last_shift = 1'b0;
    case (state_reg)
      IDLE:  load_en = bus.START;
      SHIFT: begin
        shift_en   = 1'b1;
        last_shift = (cnt_reg == LAST);
      end
      default: ;
    endcase
  end

  // Bit counter: 0..BIN_W-1 across the shift phase.
  always_ff @(posedge CLK) begin
    if (RST || load_en || last_shift) begin
      cnt_reg <= '0;
    end else if (shift_en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // ---------------- Per-channel datapath (0 = left, 1 = right) ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_ch
      logic [BIN_W-1:0] raw_val;
      logic [BIN_W-1:0] bin_reg;
      logic [15:0]      acc_reg;

      if (gi == 0) begin : g_left
        assign raw_val = bus.VALUE_1;
      end else begin : g_right
        assign raw_val = bus.VALUE_2;
      end

      assign over_w[gi]      = (raw_val > MAX_V);
      assign acc_shift_w[gi] = dd_step(acc_reg, bin_reg[BIN_W-1]);

      always_ff @(posedge CLK) begin
        if (RST) begin
          bin_reg <= '0;
          acc_reg <= '0;
        end else if (load_en) begin
          bin_reg <= over_w[gi] ? MAX_V : raw_val;
          acc_reg <= '0;
        end else if (shift_en) begin
          bin_reg <= bin_reg << 1;
          acc_reg <= acc_shift_w[gi];
        end
      end
    end
  endgenerate

  // ---------------- Result registers ----------------
  // TO_OUTPUT/OVERFLOW only move on the final shift, so the scanner never
  // sees a partially converted value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      to_output_reg <= '0;
      overflow_reg  <= 1'b0;
      ovf_cap_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= last_shift;
      if (load_en) begin
        ovf_cap_reg <= |over_w;
      end
      if (last_shift) begin
        to_output_reg <= {fmt_group(acc_shift_w[0]), fmt_group(acc_shift_w[1])};
        overflow_reg  <= ovf_cap_reg;
      end
    end
  end

  assign bus.TO_OUTPUT = to_output_reg;
  assign bus.OVERFLOW  = overflow_reg;
  assign bus.DONE      = done_reg;
  assign bus.BUSY      = (state_reg == SHIFT);

endmodule

// File: tb/tb_bcd_pair_converter.sv
// tb_bcd_pair_converter
//   Directed bench for bcd_pair_converter: reset values, conversions with
//   hand-computed BCD results, saturation, ignored START while busy,
//   reset abort and back-to-back conversions with START held high.
module tb_bcd_pair_converter;

  localparam int BIN_W = 14;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  bcd_pair_converter_if #(.BIN_W(BIN_W)) bus ();

  bcd_pair_converter #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [31:0] EXP_0_42  = 32'hFFF0FF42;
  localparam logic [31:0] EXP_1_1   = 32'hFFF1FFF1;
  localparam logic [31:0] EXP_100   = 32'hF100F200;
`else
  localparam logic [31:0] EXP_0_42  = 32'h00000042;
  localparam logic [31:0] EXP_1_1   = 32'h00010001;
  localparam logic [31:0] EXP_100   = 32'h01000200;
`endif

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a one-cycle START with the given values; returns after the accept edge.
  task automatic start_conv(input int v1, input int v2);
    bus.START   = 1'b1;
    bus.VALUE_1 = BIN_W'(v1);
    bus.VALUE_2 = BIN_W'(v2);
    tick();
    bus.START   = 1'b0;
  endtask

  // Tick until DONE is seen; cycles = ticks taken, or -1 if the bound expires.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.DONE === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.START = 1'b1;  // reset must win over START
    bus.VALUE_1 = 14'd5;
    bus.VALUE_2 = 14'd6;
    tick();
    tick();
    total++;
    if (bus.TO_OUTPUT !== 32'h0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%h busy=%b done=%b ovf=%b, required out=0 busy=0 done=0 ovf=0",
               bus.TO_OUTPUT, bus.BUSY, bus.DONE, bus.OVERFLOW);
    end
    bus.START = 1'b0;
    RST = 1'b0;
    tick();
    $display("reset: out=%h busy=%b done=%b ovf=%b", bus.TO_OUTPUT, bus.BUSY, bus.DONE, bus.OVERFLOW);
  endtask

  task automatic test_basic();
    int busy_cnt = 0;
    int hold_bad = 0;
    start_conv(1234, 5678);
    // Inputs change right after the accept edge; the result must not care.
    bus.VALUE_1 = 14'd0;
    bus.VALUE_2 = 14'd0;
    for (int i = 0; i < 14; i++) begin
      if (bus.BUSY === 1'b1) busy_cnt++;
      if (bus.TO_OUTPUT !== 32'h0 || bus.DONE !== 1'b0) hold_bad++;
      tick();
    end
    total++;
    if (busy_cnt != 14) begin
      bad++;
      $display("FAIL basic_busy: busy cycles=%0d, required 14", busy_cnt);
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL basic_hold: %0d cycles with output/done disturbed mid-conversion, required 0", hold_bad);
    end
    total++;
    if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b in cycle 15, required done=1 busy=0", bus.DONE, bus.BUSY);
    end
    total++;
    if (bus.TO_OUTPUT !== 32'h12345678 || bus.OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL basic_value: out=%h ovf=%b, required 12345678 ovf=0", bus.TO_OUTPUT, bus.OVERFLOW);
    end
    $display("basic 1234/5678: out=%h ovf=%b busy_cycles=%0d", bus.TO_OUTPUT, bus.OVERFLOW, busy_cnt);
    tick();
    total++;
    if (bus.DONE !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse: done=%b one cycle later, required 0", bus.DONE);
    end
  endtask

  task automatic test_zero_blank();
    int cyc;
    start_conv(0, 42);
    wait_done(cyc);
    total++;
    if (cyc != 14) begin
      bad++;
      $display("FAIL zero_latency: DONE after %0d cycles, required 14", cyc);
    end
    total++;
    if (bus.TO_OUTPUT !== EXP_0_42) begin
      bad++;
      $display("FAIL zero_value: out=%h, required %h", bus.TO_OUTPUT, EXP_0_42);
    end
    $display("zero 0/42: out=%h latency=%0d", bus.TO_OUTPUT, cyc);
  endtask

  task automatic test_overflow();
    int cyc;
    start_conv(12000, 9999);
    wait_done(cyc);
    total++;
    if (cyc != 14 || bus.TO_OUTPUT !== 32'h99999999 || bus.OVERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sat: out=%h ovf=%b lat=%0d, required 99999999 ovf=1 lat=14",
               bus.TO_OUTPUT, bus.OVERFLOW, cyc);
    end
    $display("overflow 12000/9999: out=%h ovf=%b", bus.TO_OUTPUT, bus.OVERFLOW);
    tick();
    start_conv(1, 1);
    total++;
    if (bus.OVERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL ovf_hold: ovf=%b mid-conversion, required 1 (held)", bus.OVERFLOW);
    end
    wait_done(cyc);
    total++;
    if (cyc != 14 || bus.TO_OUTPUT !== EXP_1_1 || bus.OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: out=%h ovf=%b lat=%0d, required %h ovf=0 lat=14",
               bus.TO_OUTPUT, bus.OVERFLOW, cyc, EXP_1_1);
    end
    $display("after overflow 1/1: out=%h ovf=%b", bus.TO_OUTPUT, bus.OVERFLOW);
    tick();
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    int first = -1;
    logic [31:0] res = '0;
    start_conv(1111, 2222);
    for (int i = 1; i <= 5; i++) tick();
    start_conv(3333, 4444);  // lands on a shift edge: must be dropped
    for (int i = 7; i <= 35; i++) begin
      tick();
      if (bus.DONE === 1'b1) begin
        dones++;
        if (first < 0) begin
          first = i;
          res = bus.TO_OUTPUT;
        end
      end
    end
    total++;
    if (dones != 1 || first != 14) begin
      bad++;
      $display("FAIL busy_done_count: pulses=%0d first=%0d, required 1 at 14", dones, first);
    end
    total++;
    if (res !== 32'h11112222) begin
      bad++;
      $display("FAIL busy_value: out=%h, required 11112222", res);
    end
    $display("busy ignore 1111/2222 (+3333/4444): out=%h dones=%0d", res, dones);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int cyc;
    start_conv(9876, 5432);
    for (int i = 0; i < 7; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++;
    if (bus.TO_OUTPUT !== 32'h0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: out=%h busy=%b done=%b ovf=%b, required all 0",
               bus.TO_OUTPUT, bus.BUSY, bus.DONE, bus.OVERFLOW);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d cycles with done/busy after abort, required 0", dones);
    end
    start_conv(9876, 5432);
    wait_done(cyc);
    total++;
    if (cyc != 14 || bus.TO_OUTPUT !== 32'h98765432) begin
      bad++;
      $display("FAIL abort_restart: out=%h lat=%0d, required 98765432 lat=14", bus.TO_OUTPUT, cyc);
    end
    $display("abort then 9876/5432: out=%h latency=%0d", bus.TO_OUTPUT, cyc);
    tick();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int first = -1;
    int last = -1;
    int gap_bad = 0;
    int val_bad = 0;
    bus.START   = 1'b1;
    bus.VALUE_1 = 14'd100;
    bus.VALUE_2 = 14'd200;
    tick();
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.DONE === 1'b1) begin
        dones++;
        if (first < 0) first = i;
        else if (i - last != 15) gap_bad++;
        last = i;
      end
      if (first >= 0 && bus.TO_OUTPUT !== EXP_100) val_bad++;
    end
    bus.START = 1'b0;
    total++;
    if (dones != 4 || first != 14 || gap_bad != 0) begin
      bad++;
      $display("FAIL b2b_timing: pulses=%0d first=%0d bad_gaps=%0d, required 4 first=14 gaps=15",
               dones, first, gap_bad);
    end
    total++;
    if (val_bad != 0) begin
      bad++;
      $display("FAIL b2b_value: %0d cycles with out!=%h (last out=%h), required 0", val_bad, EXP_100, bus.TO_OUTPUT);
    end
    $display("back-to-back 100/200: out=%h pulses=%0d", bus.TO_OUTPUT, dones);
    for (int i = 0; i < 20; i++) tick();
  endtask

  initial begin
    bus.START   = 1'b0;
    bus.VALUE_1 = '0;
    bus.VALUE_2 = '0;
    RST         = 1'b1;
    test_reset();
    test_basic();
    test_zero_blank();
    test_overflow();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_pair_converter.md
Name: bcd_pair_converter

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment scanner.
- Converts two unsigned binary values (e.g. player 1 and player 2 scores) into two 4-digit 8421 BCD groups.
- Packs the result into the 32-bit display word: value 1 drives the left four digits, value 2 the right four.
- Uses iterative shift-add-3 (double dabble), one bit per clock, both values processed in parallel.

Parameters:
- BIN_W, 14, width of each binary input. 14 bits are enough to cover 0..9999.
- MAX_VAL, 9999, saturation limit applied to each input before conversion.

Ports:
- CLK  input  1  system clock, 100MHz
- RST  input  1  synchronous, active-high reset
- START  input  1  request a conversion; sampled only in IDLE
- VALUE_1  input  BIN_W  binary value for the left digit group
- VALUE_2  input  BIN_W  binary value for the right digit group
- TO_OUTPUT  output  32  packed BCD result. [31:16] = value 1 (thousands..ones), [15:0] = value 2. Registered.
- BUSY  output  1  high while a conversion is in progress
- DONE  output  1  one-cycle pulse when TO_OUTPUT has just been updated
- OVERFLOW  output  1  high if either input exceeded MAX_VAL in the last accepted conversion. Registered; updated together with TO_OUTPUT.

Behaviour:
- Reset: clock CLK, reset RST (synchronous, active-high).
  - While RST=1 at a rising edge: state=IDLE, TO_OUTPUT=32'h0, BUSY=0, DONE=0, OVERFLOW=0, shift counter=0.
  - RST takes priority over START.
- State machine: IDLE -> SHIFT -> IDLE.
  - IDLE: if START=1 at edge k, latch min(VALUE_n, MAX_VAL) into two BIN_W-bit shift registers and clear both 16-bit BCD accumulators. Capture the overflow condition (VALUE_1>MAX_VAL or VALUE_2>MAX_VAL) internally, set BUSY=1, and go to SHIFT.
  - SHIFT: at each edge k+1..k+BIN_W, for each accumulator, first add 3 to every BCD nibble >=5. Then shift {accumulator, binary} left by one bit. The counter counts 0..BIN_W-1.
  - On the final shift (edge k+BIN_W): write both accumulators into TO_OUTPUT and the captured overflow into OVERFLOW. Set DONE=1 and BUSY=0, and return to IDLE.
- DONE is high for exactly the one cycle after the final shift edge, then cleared. START->DONE latency is BIN_W cycles (14 by default).
- TO_OUTPUT holds its previous value throughout a conversion; the downstream scanner never sees partial results.
- START while BUSY=1 is ignored; it is not queued.
- START during the DONE cycle (state already IDLE) is accepted, giving back-to-back conversions every BIN_W+1 cycles.
- VALUE_1 and VALUE_2 are sampled only on the accepting edge. Later changes do not affect the conversion in flight.
- RST mid-conversion aborts immediately, forces the reset values above, and discards the partial result.
- Every output nibble is 0..9 (or the blank code when the optional feature is enabled).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: at the final write, within each 4-digit group, zero nibbles to the left of the first non-zero digit are replaced by 4'hF, the blank code rendered dark by the segment decoder.
  - The ones digit is never blanked, so 0 shows as a single "0".
  - Example: 42 -> 16'hFF42.
- Undefined: all digits are output as-is, zero-padded (42 -> 16'h0042).
- Blanking is applied only to TO_OUTPUT. Latency is unchanged.

Test Plan:
- Reset, then VALUE_1=1234, VALUE_2=5678, START pulse -> BUSY=1 for 14 cycles; DONE pulses in cycle 15; TO_OUTPUT=32'h12345678, OVERFLOW=0.
- VALUE_1=0, VALUE_2=42, START -> TO_OUTPUT=32'h00000042. With LEADING_ZERO_BLANK_EN: 32'hFFF0FF42.
- VALUE_1=12000, VALUE_2=9999, START -> TO_OUTPUT=32'h99999999, OVERFLOW=1. A following conversion of 1/1 -> 32'h00010001, OVERFLOW=0.
- START with 1111/2222, then START again with 3333/4444 at shift 5 -> second request ignored; result 32'h11112222; exactly one DONE pulse.
- RST=1 for one cycle at shift 7 of a 9876/5432 conversion -> TO_OUTPUT=0, BUSY=0, DONE never pulses. A new START with 9876/5432 -> 32'h98765432 after 14 cycles.
- START held high continuously with 100/200 -> DONE every 15 cycles, TO_OUTPUT=32'h01000200, TO_OUTPUT stable between DONE pulses.
